gf8_reduce_seq: RTL and testbench

Iterative GF(2^8) modular reducer placed directly downstream of the 15-bit Karatsuba overlap-sum stage. It accepts one 15-bit carry-less product (degree ≤ 14) per transaction and reduces it modulo a fixed degree-8 polynomial, one bit per cycle. It returns the 8-bit field element over a valid/ready handshake. Latency is fixed and independent of the data.

---
 rtl/gf8_reduce_seq_if.sv | 21 ++
 rtl/gf8_reduce_seq.sv | 68 ++++++
 tb/tb_gf8_reduce_seq.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gf8_reduce_seq_if.sv
// Handshake bundle for the GF(2^8) reducer: product in, field element out.
// The master modport is the upstream/downstream side; the slave modport is the reducer.
interface gf8_reduce_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [14:0] in_prod;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_res;
  logic        busy;

  modport master (
    output in_valid, in_prod, out_ready,
    input  in_ready, out_valid, out_res, busy
  );

  modport slave (
    input  in_valid, in_prod, out_ready,
    output in_ready, out_valid, out_res, busy
  );
endinterface

// File: rtl/gf8_reduce_seq.sv
// Bit-serial reduction of a 15-bit carry-less product modulo a monic degree-8 polynomial.
// The reduction always takes 7 steps (bits 14..8), so latency does not depend on the data.
module gf8_reduce_seq #(
  parameter logic [8:0] POLY = 9'h11B
) (
  input  logic              clk,
  input  logic              rst_n,
  gf8_reduce_seq_if.slave   bus
);

  generate
    if (POLY[8] != 1'b1) begin : g_bad_poly
      $error("gf8_reduce_seq: POLY must have bit 8 set");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, REDUCE, DONE} state_t;

  state_t      state;
  logic [14:0] acc;
  logic [14:0] acc_step;
  logic [14:0] poly_sh;
  logic [3:0]  cnt;
  logic [7:0]  res_q;

  // Aligning POLY's leading term with bit cnt lets one XOR clear that bit.
  always_comb begin
    poly_sh  = {6'd0, POLY} << (cnt - 4'd8);
    acc_step = acc[cnt] ? (acc ^ poly_sh) : acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      res_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            acc   <= bus.in_prod;
            cnt   <= 4'd14;
            state <= REDUCE;
          end
        end
        REDUCE: begin
          acc <= acc_step;
          cnt <= cnt - 4'd1;
          if (cnt == 4'd8) begin
            res_q <= acc_step[7:0];
            state <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state == REDUCE) || (state == DONE);
  assign bus.out_res   = res_q;

endmodule

// File: tb/tb_gf8_reduce_seq.sv
// Self-checking bench: a field-arithmetic scoreboard plus directed FIPS/boundary,
// backpressure, mid-op reset and random-product scenarios.
module tb_gf8_reduce_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gf8_reduce_seq_if bus ();

  gf8_reduce_seq #(.POLY(9'h11B)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Field model: multiply by x modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1B : 8'h00);
  endfunction

  // Reduction as a linear map: XOR of (x^i mod P) over the set bits of p.
  function automatic logic [7:0] ref_reduce(input logic [14:0] p);
    logic [7:0] xp, r;
    xp = 8'h01;
    r  = 8'h00;
    for (int i = 0; i < 15; i++) begin
      if (p[i]) r ^= xp;
      xp = xtime(xp);
    end
    return r;
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, aa, bb;
    r = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) r ^= aa;
      aa = xtime(aa);
      bb = bb >> 1;
    end
    return r;
  endfunction

  function automatic logic [14:0] clmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p ^= (15'(a) << i);
    return p;
  endfunction

  // Scoreboard bookkeeping, updated on the active edge.
  logic [7:0] exp_q[$];
  int cyc = 0, acc_cyc = 0, last_acc = 0, prev_acc = 0, n_acc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(ref_reduce(bus.in_prod));
        acc_cyc  <= cyc + 1;
        prev_acc <= last_acc;
        last_acc <= cyc;
        n_acc    <= n_acc + 1;
      end
      if (bus.out_valid && bus.out_ready && exp_q.size() > 0)
        void'(exp_q.pop_front());
    end
  end

  // Compare process, sampled on the falling edge.
  logic       prev_ov = 1'b0;
  logic [7:0] held = 8'h00;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("ready_busy_excl", int'(bus.in_ready & bus.busy), 0);
      if (bus.out_valid) begin
        if (!prev_ov) begin
          if (exp_q.size() == 0) begin
            chk("spurious_out", 1, 0);
          end else begin
            chk("result", int'(bus.out_res), int'(exp_q[0]));
            chk("latency", cyc - acc_cyc, 7);
            chk("acc_hi_zero", int'(dut.acc[14:8]), 0);
          end
          held = bus.out_res;
        end else begin
          chk("hold_stable", int'(bus.out_res), int'(held));
        end
      end
      prev_ov = bus.out_valid;
    end else begin
      prev_ov = 1'b0;
    end
  end

  task automatic send(input logic [14:0] p);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_prod  = p;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) chk("valid_timeout", 0, 1);
  endtask

  task automatic wait_res(input logic [7:0] exp);
    wait_valid();
    chk("dir_res", int'(bus.out_res), int'(exp));
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int k;
    bus.in_valid  = 1'b0;
    bus.in_prod   = '0;
    bus.out_ready = 1'b0;

    // Model pins against FIPS-197 worked examples and reduction identities.
    chk("pin_clmul_57_83", int'(clmul(8'h57, 8'h83)), 'h2B79);
    chk("pin_red_2b79", int'(ref_reduce(15'h2B79)), 'hC1);
    chk("pin_red_0589", int'(ref_reduce(15'h0589)), 'hFE);
    chk("pin_red_0100", int'(ref_reduce(15'h0100)), 'h1B);
    chk("pin_gfmul_57_13", int'(gf_mul(8'h57, 8'h13)), 'hFE);

    // Reset with random inputs toggling.
    repeat (4) begin
      bus.in_valid  = 1'($urandom);
      bus.in_prod   = 15'($urandom);
      bus.out_ready = 1'($urandom);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_res", int'(bus.out_res), 0);
    chk("rst_busy", int'(bus.busy), 0);
    @(posedge clk); #1;

    // FIPS vectors back to back with out_ready high: accepts 9 cycles apart.
    bus.out_ready = 1'b1;
    send(15'h2B79);
    send(15'h0589);
    chk("accept_interval", last_acc - prev_acc, 9);
    wait_res(8'hFE);

    // Boundaries.
    send(15'h00FF); wait_res(8'hFF);
    send(15'h0100); wait_res(8'h1B);
    send(15'h0000); wait_res(8'h00);
    send(15'h7FFF); wait_res(ref_reduce(15'h7FFF));

    // Backpressure in DONE with a competing input.
    bus.out_ready = 1'b0;
    send(15'h2B79);
    wait_valid();
    bus.in_valid = 1'b1;
    bus.in_prod  = 15'h0100;
    k = n_acc;
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_out_valid", int'(bus.out_valid), 1);
      chk("bp_out_res", int'(bus.out_res), 'hC1);
      chk("bp_in_ready", int'(bus.in_ready), 0);
    end
    chk("bp_no_accept", n_acc, k);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_ready_back", int'(bus.in_ready), 1);
    chk("bp_not_yet", n_acc, k);
    @(posedge clk); #1;
    chk("bp_accepted", n_acc, k + 1);
    bus.in_valid = 1'b0;
    wait_res(8'h1B);

    // Reset during REDUCE step 3.
    send(15'h2B79);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("mid_rst_out_valid", int'(bus.out_valid), 0);
      chk("mid_rst_busy", int'(bus.busy), 0);
      chk("mid_rst_out_res", int'(bus.out_res), 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(15'h0100);
    wait_res(8'h1B);

    // Random operand pairs with random gaps and output stalls.
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] a, b;
      int n;
      a = 8'($urandom);
      b = 8'($urandom);
      bus.out_ready = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send(clmul(a, b));
      n = 0;
      while (n < 200) begin
        bus.out_ready = 1'($urandom_range(0, 1));
        if (bus.out_valid && bus.out_ready) begin
          chk("rand_res", int'(bus.out_res), int'(gf_mul(a, b)));
          @(posedge clk); #1;
          break;
        end
        @(posedge clk); #1;
        n++;
      end
      if (n >= 200) chk("rand_timeout", 0, 1);
    end

    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
